// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
//
// Data-side memory responder for the single-cycle CPU core. It answers every
// data access in the same cycle. The low half of the address space
// (addr[15] = 0) is word RAM. The high half (addr[15] = 1) holds
// memory-mapped I/O:
//   - a byte transmit FIFO, drained over a valid/ready stream;
//   - an optional 32-bit timer with a compare register and a sticky match
//     flag.
// Address bits above 15 are not decoded, so the whole map aliases every
// 64 KiB.
//
// MMIO register map (offsets from 0x8000):
//   0x00 TXDATA      write pushes din[7:0]; reads as 0
//   0x04 STATUS      [0] full, [1] empty, [2] overflow (sticky, W1C),
//                    [7:4] count saturated to 15
//   0x08 TIMER       current count; a write loads din
//   0x0C TIMER_CMP   compare value
//   0x10 TIMER_FLAG  [0] match flag (W1C)
//   0x14-0x1C        reserved: read 0, writes ignored
//
// Build option:
//   DMEM_MMIO_TIMER_EN  When defined, the timer, TIMER_CMP and TIMER_FLAG are
//                       built. When undefined, offsets 0x08-0x10 read 0,
//                       writes to them are ignored, and timer_irq is tied 0.
//
// Parameters:
//   DEPTH_LOG  log2 of the RAM depth in 32-bit words
//   FIFO_LOG   log2 of the transmit FIFO depth in bytes
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   MemWrite   write strobe from the core
//   addr       byte address (core aluout); bits [1:0] ignored
//   din        write data (core writedata)
//   dout       read data (core readdata), combinational
//   tx_data    FIFO head byte (first-word-fall-through), 0 when empty
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts tx_data this cycle
//   timer_irq  level interrupt, equal to the timer match flag
// -----------------------------------------------------------------------------
module dmem_mmio #(
    parameter int DEPTH_LOG = 10,
    parameter int FIFO_LOG  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    // MMIO register selectors, decoded from addr[4:2].
    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_TIMER  = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_FLAG   = 3'd4;

    localparam int RAM_WORDS  = 1 << DEPTH_LOG;
    localparam int FIFO_DEPTH = 1 << FIFO_LOG;

    // Count value meaning "all entries occupied".
    localparam logic [FIFO_LOG:0] FIFO_FULL_CNT = {1'b1, {FIFO_LOG{1'b0}}};

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic                 sel_mmio;
    logic [2:0]           reg_sel;
    logic [DEPTH_LOG-1:0] word_idx;
    logic                 ram_we;
    logic                 mmio_we;

    assign sel_mmio = addr[15];
    assign reg_sel  = addr[4:2];
    assign word_idx = addr[DEPTH_LOG+1:2];
    assign ram_we   = MemWrite && !sel_mmio;
    assign mmio_we  = MemWrite && sel_mmio;

    // Address bits outside the decode (aliasing bits, byte offset) are
    // deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^addr;

    // -------------------------------------------------------------------------
    // Word RAM: combinational read, write at the edge, contents not reset.
    // A write coinciding with reset is dropped so that reset wins over any
    // write in the same cycle.
    // -------------------------------------------------------------------------
    logic [31:0] ram [RAM_WORDS];
    logic [31:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[word_idx] <= din;
        end
    end

    assign ram_rdata = ram[word_idx];

    // -------------------------------------------------------------------------
    // Transmit FIFO
    //
    // Stream handshake: the FIFO presents its head byte on tx_data with
    // tx_valid high whenever it holds at least one entry; a byte is transferred
    // (popped) on every rising edge at which tx_valid && tx_ready are both
    // high. tx_data and tx_valid do not depend on tx_ready.
    //
    // A push is accepted when there is room, or when a pop in the same cycle
    // frees the head slot. A rejected push is dropped and sets the sticky
    // overflow bit. A push only becomes visible on tx_valid after the edge;
    // there is no write-to-head bypass.
    // -------------------------------------------------------------------------
    logic [7:0]          fifo_mem [FIFO_DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr;
    logic [FIFO_LOG-1:0] rd_ptr;
    logic [FIFO_LOG:0]   count;
    logic                overflow;

    logic push_req;
    logic push_ok;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic ovf_clear;

    assign fifo_full  = (count == FIFO_FULL_CNT);
    assign fifo_empty = (count == '0);
    assign pop        = tx_valid && tx_ready;
    assign push_req   = mmio_we && (reg_sel == REG_TXDATA);
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_clear  = mmio_we && (reg_sel == REG_STATUS) && din[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            fifo_mem[wr_ptr] <= din[7:0];
        end
    end

    assign tx_valid = !fifo_empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

    // STATUS count field is 4 bits wide and saturates at 15 for deep FIFOs.
    logic [31:0] count_ext;
    logic [3:0]  count_sat;
    logic [31:0] status_word;

    assign count_ext = 32'(count);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    assign status_word = {24'h0, count_sat, 1'b0, overflow, fifo_empty,
                          fifo_full};

    // -------------------------------------------------------------------------
    // Timer
    // -------------------------------------------------------------------------
    logic [31:0] timer_rd;
    logic [31:0] cmp_rd;
    logic [31:0] flag_rd;

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] timer_cnt;
    logic [31:0] timer_cmp;
    logic        timer_flag;
    logic        timer_load;
    logic        cmp_load;
    logic        flag_clear;

    assign timer_load = mmio_we && (reg_sel == REG_TIMER);
    assign cmp_load   = mmio_we && (reg_sel == REG_CMP);
    assign flag_clear = mmio_we && (reg_sel == REG_FLAG) && din[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_cnt  <= 32'h0000_0000;
            timer_cmp  <= 32'hFFFF_FFFF;
            timer_flag <= 1'b0;
        end else begin
            // A load replaces the increment for that cycle; the counter
            // wraps naturally from 0xFFFFFFFF to 0.
            if (timer_load) begin
                timer_cnt <= din;
            end else begin
                timer_cnt <= timer_cnt + 32'd1;
            end
            if (cmp_load) begin
                timer_cmp <= din;
            end
            // The match uses the pre-edge count and compare values, and a
            // match in the same cycle as a clear leaves the flag set.
            if (timer_cnt == timer_cmp) begin
                timer_flag <= 1'b1;
            end else if (flag_clear) begin
                timer_flag <= 1'b0;
            end
        end
    end

    assign timer_rd  = timer_cnt;
    assign cmp_rd    = timer_cmp;
    assign flag_rd   = {31'h0, timer_flag};
    assign timer_irq = timer_flag;
`else
    assign timer_rd  = 32'h0;
    assign cmp_rd    = 32'h0;
    assign flag_rd   = 32'h0;
    assign timer_irq = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read data mux (zero latency)
    // -------------------------------------------------------------------------
    always_comb begin
        dout = 32'h0;
        if (!sel_mmio) begin
            dout = ram_rdata;
        end else begin
            case (reg_sel)
                REG_STATUS: dout = status_word;
                REG_TIMER:  dout = timer_rd;
                REG_CMP:    dout = cmp_rd;
                REG_FLAG:   dout = flag_rd;
                default:    dout = 32'h0;   // TXDATA and reserved read 0
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
//
// Directed bench for dmem_mmio. Drivers apply one bus cycle per call (inputs
// change 1 time unit after the rising edge) and push the expected responses
// for that cycle into chk_q. The monitor samples on the falling edge and pops
// every entry tagged with the current cycle. Bytes accepted into the FIFO are
// pushed into exp_q and checked in order whenever the stream transfers
// (tx_valid && tx_ready).
// -----------------------------------------------------------------------------
module tb_dmem_mmio;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_irq;

  always #5 clk = ~clk;

  dmem_mmio dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  localparam int K_DOUT   = 0;
  localparam int K_VALID  = 1;
  localparam int K_TXDATA = 2;
  localparam int K_IRQ    = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         end_req = 1'b0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc  = cyc_cnt;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic cyc_begin(input logic rdy);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    MemWrite = 1'b0;
    tx_ready = rdy;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    cyc_begin(rdy);
    MemWrite = 1'b1;
    addr     = a;
    din      = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name,
                    input logic rdy);
    cyc_begin(rdy);
    addr = a;
    chk(K_DOUT, exp, name);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [31:0] act;
    logic [7:0]  eb;
    chk_t        c;
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc_cnt) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_DOUT:   act = dout;
        K_VALID:  act = {31'h0, tx_valid};
        K_TXDATA: act = {24'h0, tx_data};
        default:  act = {31'h0, timer_irq};
      endcase
      checks++;
      if (act !== c.exp || c.cyc != cyc_cnt) begin
        failures++;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", c.name, act, c.exp, cyc_cnt);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stream_extra: got byte %h, expected no transfer", tx_data);
      end else begin
        eb = exp_q.pop_front();
        if (tx_data !== eb) begin
          failures++;
          $display("FAIL stream_byte: got %h, expected %h", tx_data, eb);
        end
      end
    end
    if (end_req) begin
      checks++;
      if (chk_q.size() != 0 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL leftover: got %0d checks / %0d bytes pending, expected 0 / 0",
                 chk_q.size(), exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset held for two edges; first cycle after it reads TIMER.
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    addr = 32'h8008;
    chk(K_DOUT, 32'h0, "rst_timer");
    chk(K_VALID, 32'h0, "rst_tx_valid");
    chk(K_TXDATA, 32'h0, "rst_tx_data");
    chk(K_IRQ, 32'h0, "rst_irq");
    rd(32'h8004, 32'h0000_0002, "rst_status", 1'b0);
`ifdef DMEM_MMIO_TIMER_EN
    rd(32'h800C, 32'hFFFF_FFFF, "rst_cmp", 1'b0);
`else
    rd(32'h800C, 32'h0, "rst_cmp", 1'b0);
`endif
    rd(32'h8010, 32'h0, "rst_flag", 1'b0);

    // RAM
    wr(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd", 1'b0);
    rd(32'h0001_0010, 32'hDEAD_BEEF, "ram_alias", 1'b0);
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_byte_off", 1'b0);
    wr(32'h0000_0014, 32'h1234_5678, 1'b0);
    rd(32'h0000_0014, 32'h1234_5678, "ram_rd2", 1'b0);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_keep", 1'b0);

    // FIFO fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      wr(32'h8000, 32'h41 + i, 1'b0);
      exp_q.push_back(8'h41 + 8'(i));
    end
    rd(32'h8004, 32'h0000_0081, "fill_status", 1'b0);
    chk(K_VALID, 32'h1, "fill_valid");
    wr(32'h8000, 32'h49, 1'b0);
    rd(32'h8004, 32'h0000_0085, "ovf_status", 1'b0);
    chk(K_TXDATA, 32'h41, "ovf_head");
    rd(32'h8000, 32'h0, "txdata_rd", 1'b0);
    wr(32'h8004, 32'h4, 1'b0);
    rd(32'h8004, 32'h0000_0081, "ovf_clear", 1'b0);
    wr(32'h8018, 32'hFFFF_FFFF, 1'b0);
    rd(32'h8018, 32'h0, "reserved_18", 1'b0);
    rd(32'h8014, 32'h0, "reserved_14", 1'b0);

    // Drain 0x41..0x48 on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      cyc_begin(1'b1);
      chk(K_VALID, 32'h1, "drain_valid");
    end
    rd(32'h8004, 32'h0000_0002, "drain_status", 1'b1);
    chk(K_VALID, 32'h0, "drain_end");

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      wr(32'h8000, 32'h50 + i, 1'b0);
      exp_q.push_back(8'h50 + 8'(i));
    end
    wr(32'h8000, 32'h58, 1'b1);
    exp_q.push_back(8'h58);
    rd(32'h8004, 32'h0000_0081, "pushpop_status", 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc_begin(1'b1);
      chk(K_VALID, 32'h1, "pushpop_valid");
    end
    rd(32'h8004, 32'h0000_0002, "pushpop_empty", 1'b1);

    // Push into empty FIFO: no bypass
    wr(32'h8000, 32'h60, 1'b0);
    chk(K_VALID, 32'h0, "no_bypass");
    exp_q.push_back(8'h60);
    wr(32'h8000, 32'h61, 1'b0);
    chk(K_VALID, 32'h1, "valid_after_push");
    chk(K_TXDATA, 32'h60, "head_after_push");
    exp_q.push_back(8'h61);
    wr(32'h8000, 32'h62, 1'b0);
    exp_q.push_back(8'h62);

    // Reset mid-stream with a simultaneous push; contents discarded
    cyc_begin(1'b0);
    rst      = 1'b1;
    MemWrite = 1'b1;
    addr     = 32'h8000;
    din      = 32'h63;
    exp_q.delete();
    cyc_begin(1'b0);
    addr = 32'h8008;
    chk(K_DOUT, 32'h0, "rst_mid_timer");
    chk(K_VALID, 32'h0, "rst_mid_valid");
    rd(32'h8004, 32'h0000_0002, "rst_mid_status", 1'b0);

`ifdef DMEM_MMIO_TIMER_EN
    // Timer: CMP=5, load 0, flag rises 6 cycles after the load edge
    wr(32'h800C, 32'h5, 1'b0);
    wr(32'h8008, 32'h0, 1'b0);
    cyc_begin(1'b0);
    chk(K_IRQ, 32'h0, "irq_early");
    cyc_begin(1'b0);
    rd(32'h8008, 32'h2, "timer_count", 1'b0);
    cyc_begin(1'b0);
    cyc_begin(1'b0);
    cyc_begin(1'b0);
    chk(K_IRQ, 32'h0, "irq_before_match");
    rd(32'h8010, 32'h1, "flag_set", 1'b0);
    chk(K_IRQ, 32'h1, "irq_rise");

    // Clear, then match again across the wrap with CMP=0
    wr(32'h800C, 32'h0, 1'b0);
    wr(32'h8010, 32'h1, 1'b0);
    cyc_begin(1'b0);
    chk(K_IRQ, 32'h0, "flag_clear");
    wr(32'h8008, 32'hFFFF_FFFD, 1'b0);
    rd(32'h8008, 32'hFFFF_FFFD, "timer_load", 1'b0);
    chk(K_IRQ, 32'h0, "irq_pre_wrap1");
    cyc_begin(1'b0);
    cyc_begin(1'b0);
    chk(K_IRQ, 32'h0, "irq_pre_wrap2");
    rd(32'h8008, 32'h0, "timer_wrap", 1'b0);
    chk(K_IRQ, 32'h0, "irq_pre_wrap3");
    cyc_begin(1'b0);
    chk(K_IRQ, 32'h1, "irq_wrap");

    // Set wins over a simultaneous clear
    wr(32'h8010, 32'h1, 1'b0);
    wr(32'h800C, 32'h5, 1'b0);
    chk(K_IRQ, 32'h0, "flag_clear2");
    cyc_begin(1'b0);
    wr(32'h8010, 32'h1, 1'b0);
    cyc_begin(1'b0);
    chk(K_IRQ, 32'h1, "set_wins");
`else
    wr(32'h8008, 32'h1234, 1'b0);
    rd(32'h8008, 32'h0, "no_timer", 1'b0);
    wr(32'h800C, 32'h5, 1'b0);
    rd(32'h800C, 32'h0, "no_cmp", 1'b0);
    wr(32'h8010, 32'h1, 1'b0);
    rd(32'h8010, 32'h0, "no_flag", 1'b0);
    chk(K_IRQ, 32'h0, "no_irq");
`endif

    cyc_begin(1'b0);
    cyc_begin(1'b0);
    end_req = 1'b1;
  end

endmodule
